// File: rtl/display_scan_controller.sv
// Multiplexed seven-segment scan controller: one shared decoder, per-digit drive slots
// separated by all-anodes-off guard gaps, with frame-synchronous value updates.
module display_scan_controller #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int GUARD    = 4
) (
    input  logic                                        Clock,
    input  logic                                        Reset_n,
    input  logic                                        Enable,
    input  logic [4*DIGITS-1:0]                         Value,
    input  logic [DIGITS-1:0]                           Dp,
    input  logic                                        Load,
    input  logic                                        Blank_lz,
    output logic [6:0]                                  Segments,
    output logic                                        Dot,
    output logic [DIGITS-1:0]                           Anodes,
    output logic [(DIGITS > 1 ? $clog2(DIGITS) : 1)-1:0] Digit_index,
    output logic                                        Frame_done
);

    localparam int PW = $clog2(PRESCALE);
    localparam int GW = $clog2(GUARD + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [GW-1:0] GRD_LAST = GW'(GUARD - 1);
    localparam logic [IW-1:0] DIG_LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_GUARD
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       preCnt_q, preCnt_d;
    logic [GW-1:0]       grdCnt_q, grdCnt_d;
    logic [IW-1:0]       digit_q, digit_d;
    logic [4*DIGITS-1:0] activeVal_q, activeVal_d;
    logic [DIGITS-1:0]   activeDp_q, activeDp_d;
    logic [4*DIGITS-1:0] pendVal_q, pendVal_d;
    logic [DIGITS-1:0]   pendDp_q, pendDp_d;
    logic                pendFlag_q, pendFlag_d;
    logic [6:0]          segs_q, segs_d;
    logic                dot_q, dot_d;
    logic [DIGITS-1:0]   anodes_q, anodes_d;
    logic                frameDone_q, frameDone_d;

    logic                frameStart;
    logic [3:0]          nib;
    logic                dpBit;
    logic                zeroRun;
    logic                blankHere;

    function automatic logic [6:0] hexToSeg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Outputs are decoded from next-state values so they appear registered on the same
    // edge the scan position changes, including a freshly transferred frame value.
    always_comb begin
        state_d     = state_q;
        preCnt_d    = preCnt_q;
        grdCnt_d    = grdCnt_q;
        digit_d     = digit_q;
        activeVal_d = activeVal_q;
        activeDp_d  = activeDp_q;
        pendVal_d   = pendVal_q;
        pendDp_d    = pendDp_q;
        pendFlag_d  = pendFlag_q;
        frameStart  = 1'b0;
        frameDone_d = 1'b0;

        if (!Enable) begin
            state_d  = S_IDLE;
            preCnt_d = '0;
            grdCnt_d = '0;
            digit_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d    = S_DRIVE;
                    digit_d    = '0;
                    preCnt_d   = '0;
                    frameStart = 1'b1;
                end
                S_DRIVE: begin
                    if (preCnt_q == PRE_LAST) begin
                        state_d  = S_GUARD;
                        preCnt_d = '0;
                        grdCnt_d = '0;
                    end else begin
                        preCnt_d = preCnt_q + 1'b1;
                    end
                end
                S_GUARD: begin
                    if (grdCnt_q == GRD_LAST) begin
                        state_d  = S_DRIVE;
                        grdCnt_d = '0;
                        if (digit_q == DIG_LAST) begin
                            digit_d     = '0;
                            frameStart  = 1'b1;
                            frameDone_d = 1'b1;
                        end else begin
                            digit_d = digit_q + 1'b1;
                        end
                    end else begin
                        grdCnt_d = grdCnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Transfer happens before capture so a Load coinciding with a frame start waits a frame.
        if (frameStart && pendFlag_q) begin
            activeVal_d = pendVal_q;
            activeDp_d  = pendDp_q;
            pendFlag_d  = 1'b0;
        end
        if (Load) begin
            pendVal_d  = Value;
            pendDp_d   = Dp;
            pendFlag_d = 1'b1;
        end

        nib       = '0;
        dpBit     = 1'b0;
        zeroRun   = 1'b1;
        blankHere = 1'b0;
        anodes_d  = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zeroRun = zeroRun && (activeVal_d[4*i +: 4] == 4'h0);
            if (digit_d == IW'(i)) begin
                nib       = activeVal_d[4*i +: 4];
                dpBit     = activeDp_d[i];
                blankHere = Blank_lz && zeroRun && (i != 0);
                anodes_d[i] = (state_d != S_DRIVE);
            end
        end

        if (state_d == S_DRIVE) begin
            segs_d = blankHere ? 7'h7F : hexToSeg(nib);
            dot_d  = ~dpBit;
        end else begin
            segs_d = 7'h7F;
            dot_d  = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            preCnt_q    <= '0;
            grdCnt_q    <= '0;
            digit_q     <= '0;
            activeVal_q <= '0;
            activeDp_q  <= '0;
            pendVal_q   <= '0;
            pendDp_q    <= '0;
            pendFlag_q  <= 1'b0;
            segs_q      <= 7'h7F;
            dot_q       <= 1'b1;
            anodes_q    <= '1;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            preCnt_q    <= preCnt_d;
            grdCnt_q    <= grdCnt_d;
            digit_q     <= digit_d;
            activeVal_q <= activeVal_d;
            activeDp_q  <= activeDp_d;
            pendVal_q   <= pendVal_d;
            pendDp_q    <= pendDp_d;
            pendFlag_q  <= pendFlag_d;
            segs_q      <= segs_d;
            dot_q       <= dot_d;
            anodes_q    <= anodes_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign Segments    = segs_q;
    assign Dot         = dot_q;
    assign Anodes      = anodes_q;
    assign Digit_index = digit_q;
    assign Frame_done  = frameDone_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with a frame-position reference model
// compared every cycle, plus hand-computed literal checkpoints.
module tb_display_scan_controller;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;
    localparam int GUARD    = 1;
    localparam int SLOT     = PRESCALE + GUARD;
    localparam int FRAME    = DIGITS * SLOT;

    logic        clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Enable = 1'b0;
    logic [15:0] Value = '0;
    logic [3:0]  Dp = '0;
    logic        Load = 1'b0;
    logic        Blank_lz = 1'b0;
    logic [6:0]  Segments;
    logic        Dot;
    logic [3:0]  Anodes;
    logic [1:0]  Digit_index;
    logic        Frame_done;

    int passCount = 0;
    int checkCount = 0;

    display_scan_controller #(
        .DIGITS(DIGITS), .PRESCALE(PRESCALE), .GUARD(GUARD)
    ) dut (
        .Clock(clock), .Reset_n(Reset_n), .Enable(Enable), .Value(Value), .Dp(Dp),
        .Load(Load), .Blank_lz(Blank_lz), .Segments(Segments), .Dot(Dot),
        .Anodes(Anodes), .Digit_index(Digit_index), .Frame_done(Frame_done)
    );

    always #5 clock = ~clock;

    logic [6:0] segTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: tracks position within the frame since the scan started and
    // derives the expected outputs from slot/phase arithmetic.
    bit          modelValid = 0;
    bit          mOn = 0;
    int          mPos = 0;
    logic [15:0] mAct = '0, mPend = '0;
    logic [3:0]  mActDp = '0, mPendDp = '0;
    bit          mFlag = 0;
    logic [6:0]  expSeg;
    logic        expDot, expDone;
    logic [3:0]  expAn;
    int          expIdx;

    always @(posedge clock) begin
        bit fStart;
        int slot, phase;
        fStart  = 0;
        expDone = 1'b0;
        if (!Reset_n) begin
            mOn = 0; mPos = 0; mAct = '0; mPend = '0; mActDp = '0; mPendDp = '0; mFlag = 0;
        end else begin
            if (!Enable) begin
                mOn = 0; mPos = 0;
            end else if (!mOn) begin
                mOn = 1; mPos = 0; fStart = 1;
            end else begin
                mPos = (mPos + 1) % FRAME;
                if (mPos == 0) begin
                    fStart = 1; expDone = 1'b1;
                end
            end
            if (fStart && mFlag) begin
                mAct = mPend; mActDp = mPendDp; mFlag = 0;
            end
            if (Load) begin
                mPend = Value; mPendDp = Dp; mFlag = 1;
            end
        end
        expAn = 4'hF; expSeg = 7'h7F; expDot = 1'b1; expIdx = 0;
        if (mOn) begin
            slot = mPos / SLOT;
            phase = mPos % SLOT;
            expIdx = slot;
            if (phase < PRESCALE) begin
                expAn = ~(4'b0001 << slot);
                if (Blank_lz && slot > 0 && (mAct >> (4 * slot)) == 16'h0)
                    expSeg = 7'h7F;
                else
                    expSeg = segTab[(mAct >> (4 * slot)) & 16'hF];
                expDot = ~mActDp[slot];
            end
        end
        modelValid = 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            passCount++;
    endtask

    // Every-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clock) begin
        if (modelValid) begin
            checkOutput("anodes", 32'(Anodes), 32'(expAn));
            checkOutput("segments", 32'(Segments), 32'(expSeg));
            checkOutput("dot", 32'(Dot), 32'(expDot));
            checkOutput("digit_index", 32'(Digit_index), 32'(expIdx));
            checkOutput("frame_done", 32'(Frame_done), 32'(expDone));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d);
        Value = v; Dp = d; Load = 1'b1;
        tick(1);
        Load = 1'b0;
    endtask

    initial begin
        // Reset held with Enable high
        Enable = 1'b1;
        tick(3);
        checkOutput("lit_reset_anodes", 32'(Anodes), 32'h0000_000F);
        checkOutput("lit_reset_segs", 32'(Segments), 32'h0000_007F);
        checkOutput("lit_reset_done", 32'(Frame_done), 32'h0);

        // Load with the enabling edge: first frame still shows zeros
        Reset_n = 1'b1;
        applyStimulus(16'h1A2F, 4'b0000);                      // pos 0
        checkOutput("lit_f1_seg", 32'(Segments), 32'h40);
        checkOutput("lit_f1_an", 32'(Anodes), 32'hE);
        tick(4);                                                // pos 4 guard
        checkOutput("lit_guard_an", 32'(Anodes), 32'hF);
        checkOutput("lit_guard_seg", 32'(Segments), 32'h7F);
        tick(16);                                               // frame 2 pos 0
        checkOutput("lit_f2_d0", 32'(Segments), 32'h0E);
        checkOutput("lit_f2_done", 32'(Frame_done), 32'h1);
        tick(5);                                                // pos 5
        checkOutput("lit_f2_d1", 32'(Segments), 32'h24);

        // Leading-zero blanking with a decimal point on a blanked digit
        Blank_lz = 1'b1;
        applyStimulus(16'h0005, 4'b0100);                       // pos 6
        tick(14);                                               // frame 3 pos 0
        checkOutput("lit_lz_d0", 32'(Segments), 32'h12);
        tick(5);
        checkOutput("lit_lz_d1", 32'(Segments), 32'h7F);
        tick(5);
        checkOutput("lit_lz_d2", 32'(Segments), 32'h7F);
        checkOutput("lit_lz_dot", 32'(Dot), 32'h0);
        tick(5);                                                // pos 15
        checkOutput("lit_lz_d3", 32'(Segments), 32'h7F);
        Blank_lz = 1'b0;
        tick(10);                                               // frame 4 pos 5
        checkOutput("lit_nolz_d1", 32'(Segments), 32'h40);

        // Two loads within a frame: last write wins
        applyStimulus(16'h1111, 4'b0000);                       // pos 6
        tick(3);                                                // pos 9
        applyStimulus(16'h2222, 4'b0000);                       // pos 10
        tick(10);                                               // frame 5 pos 0
        checkOutput("lit_lww_d0", 32'(Segments), 32'h24);
        tick(5);
        checkOutput("lit_lww_d1", 32'(Segments), 32'h24);

        // Drop Enable during digit 2 drive, then restart
        tick(6);                                                // pos 11
        Enable = 1'b0;
        tick(1);
        checkOutput("lit_dis_an", 32'(Anodes), 32'hF);
        checkOutput("lit_dis_idx", 32'(Digit_index), 32'h0);
        tick(3);
        Enable = 1'b1;
        tick(1);                                                // pos 0
        checkOutput("lit_reen_an", 32'(Anodes), 32'hE);
        tick(19);                                               // pos 19
        checkOutput("lit_reen_nodone", 32'(Frame_done), 32'h0);

        // Load coinciding with a frame start shows only in the following frame
        applyStimulus(16'h3333, 4'b0000);                       // frame start
        checkOutput("lit_fs_done", 32'(Frame_done), 32'h1);
        checkOutput("lit_fs_old", 32'(Segments), 32'h24);
        tick(20);
        checkOutput("lit_fs_new", 32'(Segments), 32'h30);

        // Reset during a guard gap
        tick(4);                                                // pos 4 guard
        Reset_n = 1'b0;
        tick(1);
        checkOutput("lit_rst_an", 32'(Anodes), 32'hF);
        checkOutput("lit_rst_seg", 32'(Segments), 32'h7F);
        Reset_n = 1'b1;
        tick(1);
        checkOutput("lit_rst_cleared", 32'(Segments), 32'h40);
        tick(25);

        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
